// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if
// Request/response bundle between the execute-stage control and the
// iterative shift sequencer.
//   start   : request strobe (control -> sequencer), sampled only when idle
//   sh_dir  : 1 = right shift, 0 = left shift
//   sgn     : 1 = arithmetic right shift (sign fill); ignored for left shifts
//   amt     : shift amount, 0 .. 2**AMT_W-1
//   operand : value to shift
//   result  : working/final result (sequencer -> control)
//   valid   : one-cycle strobe, result is final
//   busy    : sequencer is not idle
// Modports: master = requesting control, slave = sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) ();

  logic             start;
  logic             sh_dir;
  logic             sgn;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             busy;

  modport master (
    output start, sh_dir, sgn, amt, operand,
    input  result, valid, busy
  );

  modport slave (
    input  start, sh_dir, sgn, amt, operand,
    output result, valid, busy
  );

endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-cycle shift controller: replaces a single-cycle barrel shifter with
// one coarse (4-bit) or fine (1-bit) shift step per clock. A request is
// latched on the accepting edge, shifted for AMT/4 + AMT%4 clocks, then the
// result is flagged final by a one-cycle valid strobe.
// Ports:
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset
//   bus    : shift_sequencer_if.slave (start/sh_dir/sgn/amt/operand in,
//            result/valid/busy out)
// WIDTH must equal 2**AMT_W.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  shift_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic [AMT_W-1:0] rem_q;
  logic             dir_q;
  logic             fill_q;
  logic             valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] step_d;
  logic [AMT_W-1:0] rem_d;
  logic             last_d;

  localparam logic [AMT_W-1:0] COARSE = AMT_W'(4);
  localparam logic [AMT_W-1:0] FINE   = AMT_W'(1);

  // One shift step on the working register. Coarse steps are taken while at
  // least four positions remain, so the amount is consumed greedily.
  function automatic logic [WIDTH-1:0] step_fn(
    input logic [WIDTH-1:0] val,
    input logic             coarse,
    input logic             right,
    input logic             fill
  );
    logic [WIDTH-1:0] r;
    if (coarse) begin
      if (right) r = {{4{fill}}, val[WIDTH-1:4]};
      else       r = {val[WIDTH-5:0], 4'b0000};
    end else begin
      if (right) r = {fill, val[WIDTH-1:1]};
      else       r = {val[WIDTH-2:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    step_d = result_q;
    rem_d  = rem_q;
    last_d = 1'b0;
    if (rem_q >= COARSE) begin
      step_d = step_fn(result_q, 1'b1, dir_q, fill_q);
      rem_d  = rem_q - COARSE;
    end else if (rem_q != '0) begin
      step_d = step_fn(result_q, 1'b0, dir_q, fill_q);
      rem_d  = rem_q - FINE;
    end else begin
      last_d = 1'b1;
    end
  end

  // Control and data share one reset domain: a reset anywhere discards the
  // in-flight operation and clears the visible result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      result_q <= '0;
      rem_q    <= '0;
      dir_q    <= 1'b0;
      fill_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.start) begin
            result_q <= bus.operand;
            rem_q    <= bus.amt;
            dir_q    <= bus.sh_dir;
            // Fill bit is frozen here so later operand/sgn changes are inert;
            // left shifts always zero-fill.
            fill_q   <= bus.sgn & bus.sh_dir & bus.operand[WIDTH-1];
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_d) begin
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            result_q <= step_d;
            rem_q    <= rem_d;
          end
        end
        DONE: begin
          // START here is dropped, not queued.
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errs;

  shift_sequencer_if #(.WIDTH(32), .AMT_W(5)) bus ();

  shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the don't-care inputs after accept, and
  // follow the operation until BUSY drops. Optionally fires a second START
  // while the first operation is in flight.
  task automatic run_op(input string tag, input logic dir, input logic sgn,
                        input logic [4:0] amt, input logic [31:0] opnd,
                        input logic [31:0] exp_res, input int exp_lat,
                        input logic intrude);
    int lat;
    int busy_cnt;
    int valid_cnt;
    logic [31:0] res;
    bit done;
    lat = 0; busy_cnt = 0; valid_cnt = 0; res = '0; done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.sh_dir = dir; bus.sgn = sgn;
    bus.amt = amt; bus.operand = opnd;
    @(posedge clk); #1;  // E0
    bus.start = 1'b0;
    bus.operand = ~opnd;
    bus.sgn = ~sgn;
    bus.amt = 5'd31;
    if (bus.busy) busy_cnt++;
    chk({tag, ".valid_e0"}, {31'd0, bus.valid}, 32'd0);
    for (int k = 1; k <= 25 && !done; k++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_cnt++;
      if (bus.valid) begin
        valid_cnt++;
        lat = k;
        res = bus.result;
      end
      if (intrude && k == 1) begin
        bus.start = 1'b1; bus.sh_dir = 1'b0; bus.amt = 5'd3;
        bus.operand = 32'hDEAD_BEEF;
      end else if (intrude && k == 2) begin
        bus.start = 1'b0;
      end
      if (!bus.busy) done = 1;
    end
    chk({tag, ".finished"}, {31'd0, done}, 32'd1);
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"}, res, exp_res);
    chk({tag, ".valid_pulses"}, valid_cnt, 32'd1);
    chk({tag, ".busy_cycles"}, busy_cnt, exp_lat + 1);
    // Result must hold while idle, with no further strobe.
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".hold"}, bus.result, exp_res);
    chk({tag, ".idle_valid"}, {31'd0, bus.valid}, 32'd0);
    chk({tag, ".idle_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errs = 0;
    bus.start = 1'b0; bus.sh_dir = 1'b0; bus.sgn = 1'b0;
    bus.amt = '0; bus.operand = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.result", bus.result, 32'h0);
    chk("rst.valid", {31'd0, bus.valid}, 32'd0);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // tag, dir, sgn, amt, operand, expected, latency(N+1), intrude
    run_op("l_amt0",   1'b0, 1'b0, 5'd0,  32'h1234_5678, 32'h1234_5678, 1,  1'b0);
    run_op("l_amt9",   1'b0, 1'b0, 5'd9,  32'h0000_0001, 32'h0000_0200, 4,  1'b0);
    run_op("r_u_amt6", 1'b1, 1'b0, 5'd6,  32'hF000_0000, 32'h03C0_0000, 4,  1'b0);
    run_op("r_s_amt31",1'b1, 1'b1, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 11, 1'b0);
    run_op("r_s_amt4", 1'b1, 1'b1, 5'd4,  32'h7FFF_FFFF, 32'h07FF_FFFF, 2,  1'b1);
    run_op("l_sgn3",   1'b0, 1'b1, 5'd3,  32'h8000_0001, 32'h0000_0008, 4,  1'b0);
    run_op("r_s_amt1", 1'b1, 1'b1, 5'd1,  32'h8000_0002, 32'hC000_0001, 2,  1'b0);

    // Reset in the middle of a long left shift.
    @(negedge clk);
    bus.start = 1'b1; bus.sh_dir = 1'b0; bus.sgn = 1'b0;
    bus.amt = 5'd31; bus.operand = 32'h0000_0001;
    @(posedge clk); #1;  // E0
    bus.start = 1'b0;
    repeat (3) @(posedge clk);  // E1..E3
    #2;
    chk("mid.busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.result", bus.result, 32'h0);
    chk("mid.busy", {31'd0, bus.busy}, 32'd0);
    chk("mid.valid", {31'd0, bus.valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 1'b0, 1'b0, 5'd1, 32'h0000_0001, 32'h0000_0002, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
